muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit, one operation in flight at a time.
//
// Multiply is unsigned shift-add on operand magnitudes into a 2*DATA_W product.
// Divide is restoring division, one quotient bit per cycle, on magnitudes.
// Sign fixups are applied on the last iteration. Divide-by-zero and signed
// overflow are resolved at acceptance and skip the iteration phase.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset; aborts any operation in flight
//   i_valid   operation request, sampled only while o_ready=1
//   i_funct3  RV64M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   i_rs1     operand A
//   i_rs2     operand B
//   i_rd      destination register index
//   o_ready   unit idle and able to accept
//   o_valid   one-cycle result strobe (register file write enable)
//   o_rd      destination index, valid with o_valid
//   o_result  result, valid with o_valid
module muldiv_unit #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    input  logic [4:0]        i_rd,
    output logic              o_ready,
    output logic              o_valid,
    output logic [4:0]        o_rd,
    output logic [DATA_W-1:0] o_result
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_q, neg_d;
    // b_q: multiplicand (mul) or divisor (div) magnitude.
    // hi_q/lo_q: product high/low halves (mul) or remainder/dividend-quotient (div).
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [4:0]          rd_q, rd_d;

    // ---------------- Acceptance decode ----------------
    logic              acc_div;
    logic              rs1_signed, rs2_signed;
    logic              rs1_neg, rs2_neg;
    logic [DATA_W-1:0] mag1, mag2;
    logic              acc_neg;
    logic              div_zero, div_ovf;
    logic [DATA_W-1:0] special_res;

    always_comb begin
        acc_div    = i_funct3[2];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
        rs1_signed = acc_div ? ~i_funct3[0]
                             : (i_funct3[1:0] == 2'b01) || (i_funct3[1:0] == 2'b10);
        rs2_signed = acc_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
        rs1_neg    = rs1_signed & i_rs1[DATA_W-1];
        rs2_neg    = rs2_signed & i_rs2[DATA_W-1];
        mag1       = rs1_neg ? -i_rs1 : i_rs1;
        mag2       = rs2_neg ? -i_rs2 : i_rs2;
        // Remainder follows the dividend sign; quotient and product follow the sign xor.
        acc_neg    = (acc_div && i_funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div_zero   = acc_div && (i_rs2 == '0);
        div_ovf    = acc_div && !i_funct3[0]
                     && (i_rs1 == {1'b1, {(DATA_W-1){1'b0}}}) && (i_rs2 == '1);
        if (div_zero) begin
            special_res = i_funct3[1] ? i_rs1 : '1;
        end else begin
            special_res = i_funct3[1] ? '0 : i_rs1;
        end
    end

    // ---------------- Iteration datapath ----------------
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi_n, mul_lo_n;
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_hi_n, div_lo_n;
    logic [2*DATA_W-1:0] prod_n, prod_fix;
    logic [DATA_W-1:0]   mul_res, div_val, div_res, final_res;

    always_comb begin
        // Shift-add: conditionally add multiplicand into the high half, then shift right.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_n = mul_sum[DATA_W:1];
        mul_lo_n = {mul_sum[0], lo_q[DATA_W-1:1]};

        // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
        div_sh   = {hi_q, lo_q[DATA_W-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        // When div_ge holds the difference is below b_q, so the low DATA_W bits suffice.
        div_hi_n = div_ge ? (div_sh[DATA_W-1:0] - b_q) : div_sh[DATA_W-1:0];
        div_lo_n = {lo_q[DATA_W-2:0], div_ge};

        prod_n   = {mul_hi_n, mul_lo_n};
        prod_fix = neg_q ? -prod_n : prod_n;
        mul_res  = (funct3_q[1:0] == 2'b00) ? prod_fix[DATA_W-1:0]
                                            : prod_fix[2*DATA_W-1:DATA_W];
        div_val  = funct3_q[1] ? div_hi_n : div_lo_n;
        div_res  = neg_q ? -div_val : div_val;
        final_res = funct3_q[2] ? div_res : mul_res;
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        rd_d     = rd_q;
        o_ready  = 1'b0;
        o_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    funct3_d = i_funct3;
                    rd_d     = i_rd;
                    neg_d    = acc_neg;
                    cnt_d    = '0;
                    hi_d     = '0;
                    if (acc_div) begin
                        lo_d = mag1;
                        b_d  = mag2;
                    end else begin
                        lo_d = mag2;
                        b_d  = mag1;
                    end
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (funct3_q[2]) begin
                    hi_d = div_hi_n;
                    lo_d = div_lo_n;
                end else begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    result_d = final_res;
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                o_valid = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign o_rd     = rd_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, reset abort, ignored
// requests while busy, and randomized operations against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] MinS = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [2:0]   f3;
    logic [W-1:0] rs1, rs2;
    logic [4:0]   rd;
    logic         ready, ovalid;
    logic [4:0]   ord;
    logic [W-1:0] res;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_W(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_funct3 (f3),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_rd     (rd),
        .o_ready  (ready),
        .o_valid  (ovalid),
        .o_rd     (ord),
        .o_result (res)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    function automatic logic [W-1:0] ref_result(input logic [2:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] p;
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[W-1:0]; end
            3'd1: begin
                p = $signed({{64{a[W-1]}}, a}) * $signed({{64{b[W-1]}}, b});
                return p[2*W-1:W];
            end
            3'd2: begin p = {{64{a[W-1]}}, a} * {64'b0, b}; return p[2*W-1:W]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[2*W-1:W]; end
            3'd4: begin
                if (b == 0) return Ones;
                if (a == MinS && b == Ones) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? Ones : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinS && b == Ones) return '0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MinS && b == Ones));
    endfunction

    // Model of the handshake: m_left counts edges until the result cycle.
    bit           m_ok  = 1'b0;
    bit           m_act = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic [4:0]   m_rd = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok   <= 1'b1;
            m_act  <= 1'b0;
            m_left <= 0;
        end else if (m_act) begin
            if (m_left == 0) m_act <= 1'b0;
            else             m_left <= m_left - 1;
        end else if (valid) begin
            m_act  <= 1'b1;
            m_left <= is_special(f3, rs1, rs2) ? 0 : int'(W);
            m_res  <= ref_result(f3, rs1, rs2);
            m_rd   <= rd;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("ready", 64'(ready), 64'(!m_act));
            chk("valid", 64'(ovalid), 64'(m_act && m_left == 0));
            if (m_act && m_left == 0) begin
                chk("result", res, m_res);
                chk("rd", 64'(ord), 64'(m_rd));
            end
        end
    end

    // ---------------- Driver tasks ----------------
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] d);
        int n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: ready=%b after %0d cycles, expected 1", ready, n);
        end
        valid = 1'b1;
        f3 = f;
        rs1 = a;
        rs2 = b;
        rd = d;
        @(negedge clk);
        // Scramble inputs after acceptance; the unit must have latched them.
        valid = 1'b0;
        f3 = 3'($urandom);
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        rd = 5'($urandom);
    endtask

    task automatic wait_result(output logic [W-1:0] r, output logic [4:0] d, output int lat);
        int n = 0;
        while (ovalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ovalid !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL result_timeout: o_valid=%b after %0d cycles, expected 1", ovalid, n);
            r = 'x;
            d = 'x;
        end else begin
            r = res;
            d = ord;
        end
        lat = n;
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] d, input logic [W-1:0] exp,
                       input int exp_lat);
        logic [W-1:0] r;
        logic [4:0]   rr;
        int           lat;
        issue(f, a, b, d);
        wait_result(r, rr, lat);
        chk(name, r, exp);
        chk({name, "_rd"}, 64'(rr), 64'(d));
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return Ones;
            2: return MinS;
            3: return 64'($urandom_range(0, 100));
            4: return -64'($urandom_range(1, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [W-1:0] r;
        logic [4:0]   rr;
        int           lat;
        int           cnt;

        // Model pinning with hand-computed values.
        chk("model_mul", ref_result(3'd0, 64'd7, -64'd3), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_mulh", ref_result(3'd1, Ones, Ones), 64'd0);
        chk("model_mulhsu", ref_result(3'd2, Ones, 64'd2), Ones);
        chk("model_div", ref_result(3'd4, -64'd20, 64'd6), -64'd3);
        chk("model_rem", ref_result(3'd6, -64'd20, 64'd6), -64'd2);

        // Reset with a request held: nothing may be accepted.
        rst = 1'b1;
        valid = 1'b1;
        f3 = 3'd0;
        rs1 = 64'd5;
        rs2 = 64'd6;
        rd = 5'd3;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(ovalid), 64'd0);
        chk("rst_result", res, 64'd0);
        chk("rst_rd", 64'(ord), 64'd0);
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);

        run("mul", 3'd0, 64'd7, -64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 64);
        chk("mul_ready_after", 64'(ready), 64'd1);
        run("mulhu", 3'd3, Ones, Ones, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run("mulh", 3'd1, Ones, Ones, 5'd7, 64'd0, 64);
        run("mulhsu", 3'd2, Ones, 64'd2, 5'd8, Ones, 64);
        run("div", 3'd4, -64'd20, 64'd6, 5'd9, -64'd3, 64);
        run("rem", 3'd6, -64'd20, 64'd6, 5'd10, -64'd2, 64);
        run("divu", 3'd5, 64'd20, 64'd6, 5'd11, 64'd3, 64);
        run("remu", 3'd7, 64'd20, 64'd6, 5'd12, 64'd2, 64);
        run("divu_by0", 3'd5, 64'h1234, 64'd0, 5'd13, Ones, 0);
        run("remu_by0", 3'd7, 64'h1234, 64'd0, 5'd14, 64'h1234, 0);
        run("div_ovf", 3'd4, MinS, Ones, 5'd15, MinS, 0);
        run("rem_ovf", 3'd6, MinS, Ones, 5'd16, 64'd0, 0);

        // Reset while the iteration counter is at 30.
        issue(3'd0, 64'd100, 64'd200, 5'd17);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (ovalid === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("abort_no_valid", 64'(cnt), 64'd0);
        run("mul_after_abort", 3'd0, 64'd3, 64'd4, 5'd18, 64'd12, 64);

        // Requests while busy are ignored.
        issue(3'd4, -64'd20, 64'd6, 5'd19);
        repeat (10) @(negedge clk);
        valid = 1'b1;
        f3 = 3'd0;
        rs1 = 64'd9;
        rs2 = 64'd9;
        rd = 5'd20;
        @(negedge clk);
        valid = 1'b0;
        wait_result(r, rr, lat);
        chk("busy_ignore_result", r, -64'd3);
        chk("busy_ignore_rd", 64'(rr), 64'd19);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (ovalid === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("busy_no_second_valid", 64'(cnt), 64'd0);

        // Randomized operations; the compare process checks every cycle.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom), pick(), pick(), 5'($urandom));
            wait_result(r, rr, lat);
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
